reg_bank_arbiter: RTL and testbench

//  Shares one bank of NUM_REG octal load registers (clock-enabled, clearable) among NUM_REQ requesters.

---
 rtl/reg_arb_pkg.sv | 39 +++
 rtl/reg_bank_arbiter_rr_arbiter.sv | 21 ++
 rtl/reg_bank_arbiter.sv | 125 ++++++++++++
 tb/tb_reg_bank_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared definitions for reg_bank_arbiter: FSM state type, round-robin pick and one-hot address decode.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LOAD  = 2'd2
    } state_e;

    localparam int MAX_REQ = 8;
    localparam int MAX_REG = 16;

    // First set bit of valid at or after ptr, wrapping at n; returns ptr when nothing is set.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        int   pick;
        int   idx;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (ptr + i) % n;
            if (i < n && !found && ((valid >> idx) & 8'd1) != 8'd0) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [MAX_REG-1:0] onehot(input int addr, input int n);
        logic [MAX_REG-1:0] v;
        v = '0;
        if (addr >= 0 && addr < n) begin
            v = 16'd1 << addr;
        end
        return v;
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// Combinational round-robin selector: index of the first valid requester at or after ptr.
module rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      win
);

    logic [MAX_REQ-1:0] valid_ext;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = valid;
        win                      = GW'(rr_pick(valid_ext, int'(ptr), NUM_REQ));
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter for a shared register bank: IDLE -> SETUP (data on bus) -> LOAD (one-hot load + ready).
// Optional clear requests are enabled with the REG_ARB_CLEAR_EN macro.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_REG = 8,
    parameter int DATA_W  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*$clog2(NUM_REG)-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]            req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   req_err,
    output logic [DATA_W-1:0]                    reg_d,
    output logic [NUM_REG-1:0]                   reg_load,
    output logic                                 busy,
`ifdef REG_ARB_CLEAR_EN
    input  logic [NUM_REQ-1:0]                   req_clr,
    output logic [NUM_REG-1:0]                   reg_clr,
`endif
    output logic [$clog2(NUM_REQ)-1:0]           grant_id
);

    localparam int AW = $clog2(NUM_REG);
    localparam int GW = $clog2(NUM_REQ);

    state_e            state_q, state_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [GW-1:0]     win_q, win_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [GW-1:0]     arb_win;
`ifdef REG_ARB_CLEAR_EN
    logic              clr_q, clr_d;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .valid (req_valid),
        .ptr   (ptr_q),
        .win   (arb_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef REG_ARB_CLEAR_EN
            clr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef REG_ARB_CLEAR_EN
            clr_q   <= clr_d;
`endif
        end
    end

    // The request is captured once in IDLE; later input changes never reach the bus or the decode.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        addr_d    = addr_q;
        data_d    = data_q;
`ifdef REG_ARB_CLEAR_EN
        clr_d     = clr_q;
        reg_clr   = '0;
`endif
        req_ready = '0;
        req_err   = '0;
        reg_load  = '0;
        busy      = (state_q != IDLE);
        reg_d     = data_q;
        grant_id  = win_q;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    win_d   = arb_win;
                    addr_d  = req_addr[arb_win*AW +: AW];
                    data_d  = req_data[arb_win*DATA_W +: DATA_W];
`ifdef REG_ARB_CLEAR_EN
                    clr_d   = req_clr[arb_win];
`endif
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = LOAD;
            end
            LOAD: begin
                req_ready[win_q] = 1'b1;
                if (int'(addr_q) >= NUM_REG) begin
                    req_err[win_q] = 1'b1;
                end
`ifdef REG_ARB_CLEAR_EN
                else if (clr_q) begin
                    reg_clr = NUM_REG'(onehot(int'(addr_q), NUM_REG));
                end
`endif
                else begin
                    reg_load = NUM_REG'(onehot(int'(addr_q), NUM_REG));
                end
                ptr_d   = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: a transaction-level model checked every cycle plus directed literal checks.
// NUM_REG is 6 so that out-of-range addresses are representable in the 3-bit address field.
module tb_reg_bank_arbiter;

    localparam int NREQ = 4;
    localparam int NREG = 6;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int GW   = 2;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_err;
    logic [DW-1:0]        reg_d;
    logic [NREG-1:0]      reg_load;
    logic                 busy;
    logic [GW-1:0]        grant_id;
`ifdef REG_ARB_CLEAR_EN
    logic [NREQ-1:0]      req_clr;
    logic [NREG-1:0]      reg_clr;
`endif

    int checks = 0;
    int errors = 0;
    int grant_log[$];

    reg_bank_arbiter #(
        .NUM_REQ (NREQ),
        .NUM_REG (NREG),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .req_err   (req_err),
        .reg_d     (reg_d),
        .reg_load  (reg_load),
        .busy      (busy),
`ifdef REG_ARB_CLEAR_EN
        .req_clr   (req_clr),
        .reg_clr   (reg_clr),
`endif
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction model: phase counts cycles since a grant; the winner is found by scanning from the pointer.
    int m_phase = 0;
    int m_ptr   = 0;
    int m_win   = 0;
    int m_addr  = 0;
    int m_data  = 0;
    int m_clr   = 0;

    always @(negedge clk) begin
        logic [31:0] e_ready;
        logic [31:0] e_err;
        logic [31:0] e_load;
        logic [31:0] e_clr;
        int          idx;
        bit          found;
        e_ready = 32'd0;
        e_err   = 32'd0;
        e_load  = 32'd0;
        e_clr   = 32'd0;
        if (m_phase == 2) begin
            e_ready = 32'd1 << m_win;
            if (m_addr >= NREG) e_err = e_ready;
            else if (m_clr != 0) e_clr = 32'd1 << m_addr;
            else e_load = 32'd1 << m_addr;
        end
        checkOutput("model busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
        checkOutput("model reg_d", 32'(reg_d), m_data);
        checkOutput("model grant_id", 32'(grant_id), m_win);
        checkOutput("model req_ready", 32'(req_ready), e_ready);
        checkOutput("model req_err", 32'(req_err), e_err);
        checkOutput("model reg_load", 32'(reg_load), e_load);
`ifdef REG_ARB_CLEAR_EN
        checkOutput("model reg_clr", 32'(reg_clr), e_clr);
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] === 1'b1) grant_log.push_back(i);
        end

        if (rst) begin
            m_phase = 0; m_ptr = 0; m_win = 0; m_addr = 0; m_data = 0; m_clr = 0;
        end else if (m_phase == 0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && req_valid[idx]) begin
                    found  = 1'b1;
                    m_win  = idx;
                    m_addr = int'(req_addr[idx*AW +: AW]);
                    m_data = int'(req_data[idx*DW +: DW]);
`ifdef REG_ARB_CLEAR_EN
                    m_clr  = req_clr[idx] ? 1 : 0;
`endif
                end
            end
            if (found) m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_ptr   = (m_win + 1) % NREQ;
            m_phase = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid);
        req_valid = valid;
    endtask

    task automatic set_req(input int i, input int a, input int d);
        req_addr[i*AW +: AW] = AW'(a);
        req_data[i*DW +: DW] = DW'(d);
    endtask

    // One isolated request from IDLE: sampled, SETUP, LOAD, back to IDLE.
    task automatic run_single(input string tag, input int who, input int a, input int d,
                              input logic [31:0] exp_load, input logic [31:0] exp_err);
        next_cycle();
        set_req(who, a, d);
        applyStimulus(4'b0001 << who);
        next_cycle();
        @(negedge clk);
        checkOutput({tag, " setup busy"}, 32'(busy), 32'd1);
        checkOutput({tag, " setup reg_d"}, 32'(reg_d), d);
        checkOutput({tag, " setup reg_load"}, 32'(reg_load), 32'd0);
        checkOutput({tag, " setup ready"}, 32'(req_ready), 32'd0);
        next_cycle();
        @(negedge clk);
        checkOutput({tag, " load reg_load"}, 32'(reg_load), exp_load);
        checkOutput({tag, " load ready"}, 32'(req_ready), 32'd1 << who);
        checkOutput({tag, " load err"}, 32'(req_err), exp_err);
        checkOutput({tag, " load reg_d"}, 32'(reg_d), d);
        next_cycle();
        applyStimulus(4'b0000);
        @(negedge clk);
        checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " idle ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, " idle reg_d hold"}, 32'(reg_d), d);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
`ifdef REG_ARB_CLEAR_EN
        req_clr   = '0;
`endif
        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset reg_d", 32'(reg_d), 32'd0);
        checkOutput("reset reg_load", 32'(reg_load), 32'd0);
        checkOutput("reset ready", 32'(req_ready), 32'd0);
        checkOutput("reset grant_id", 32'(grant_id), 32'd0);

        $display("[TB] single write to register 3");
        run_single("t1", 0, 3, 'hA5, 32'h08, 32'h0);

        $display("[TB] out-of-range and boundary addresses");
        run_single("t3 addr7", 2, 7, 'h5A, 32'h0, 32'h4);
        run_single("t3 addr6", 2, 6, 'h66, 32'h0, 32'h4);
        run_single("t3 addr5", 2, 5, 'h55, 32'h20, 32'h0);

        $display("[TB] all requesters held valid from reset");
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, i, 'h10 + i);
        applyStimulus(4'b1111);
        next_cycle();
        rst = 1'b0;
        grant_log.delete();
        for (int k = 0; k < 40 && grant_log.size() < 5; k++) next_cycle();
        applyStimulus(4'b0000);
        checkOutput("t2 grant count", grant_log.size(), 32'd5);
        for (int j = 0; j < 5; j++) begin
            checkOutput($sformatf("t2 grant order %0d", j),
                        (j < grant_log.size()) ? grant_log[j] : 32'hFFFF_FFFF, exp_order[j]);
        end

        $display("[TB] requester drops valid during SETUP");
        next_cycle();
        set_req(1, 2, 'h3C);
        applyStimulus(4'b0010);
        next_cycle();
        applyStimulus(4'b0000);
        set_req(1, 4, 'hFF);
        @(negedge clk);
        checkOutput("t5 setup reg_d", 32'(reg_d), 32'h3C);
        next_cycle();
        @(negedge clk);
        checkOutput("t5 load reg_load", 32'(reg_load), 32'h04);
        checkOutput("t5 load ready", 32'(req_ready), 32'h2);
        checkOutput("t5 load reg_d", 32'(reg_d), 32'h3C);
        next_cycle();

        $display("[TB] reset during SETUP");
        set_req(3, 1, 'h77);
        applyStimulus(4'b1000);
        next_cycle();
        rst = 1'b1;
        applyStimulus(4'b0000);
        next_cycle();
        @(negedge clk);
        checkOutput("t4 reg_load", 32'(reg_load), 32'd0);
        checkOutput("t4 ready", 32'(req_ready), 32'd0);
        checkOutput("t4 busy", 32'(busy), 32'd0);
        checkOutput("t4 reg_d", 32'(reg_d), 32'd0);
        next_cycle();
        rst = 1'b0;
        set_req(0, 0, 'h11);
        set_req(2, 2, 'h22);
        applyStimulus(4'b0101);
        next_cycle();
        @(negedge clk);
        checkOutput("t4 first grant", 32'(grant_id), 32'd0);
        checkOutput("t4 first reg_d", 32'(reg_d), 32'h11);
        next_cycle();
        @(negedge clk);
        checkOutput("t4 first ready", 32'(req_ready), 32'h1);
        checkOutput("t4 first reg_load", 32'(reg_load), 32'h01);
        next_cycle();
        applyStimulus(4'b0100);
        next_cycle();
        @(negedge clk);
        checkOutput("t4 second grant", 32'(grant_id), 32'd2);
        checkOutput("t4 second reg_d", 32'(reg_d), 32'h22);
        next_cycle();
        @(negedge clk);
        checkOutput("t4 second ready", 32'(req_ready), 32'h4);
        checkOutput("t4 second reg_load", 32'(reg_load), 32'h04);
        next_cycle();
        applyStimulus(4'b0000);

`ifdef REG_ARB_CLEAR_EN
        $display("[TB] clear request");
        next_cycle();
        set_req(0, 5, 'h99);
        req_clr = 4'b0001;
        applyStimulus(4'b0001);
        next_cycle();
        @(negedge clk);
        checkOutput("t6 setup reg_clr", 32'(reg_clr), 32'd0);
        next_cycle();
        @(negedge clk);
        checkOutput("t6 load reg_clr", 32'(reg_clr), 32'h20);
        checkOutput("t6 load reg_load", 32'(reg_load), 32'd0);
        checkOutput("t6 load ready", 32'(req_ready), 32'h1);
        next_cycle();
        applyStimulus(4'b0000);
        req_clr = 4'b0000;
`endif

        repeat (3) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
